// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//   Shared types and sizing helpers for the PISO serializer slice.
//
//   Contents:
//     state_t     - serializer FSM state (IDLE, SHIFT)
//     frame_len() - serial frame length for a given word width
//     cnt_width() - bit-counter width for a given word width
//     CNT_W       - counter width for the default 10-bit symbol link
//
//   Configuration macro:
//     PISO_PARITY_EN - when defined, every frame carries a trailing
//                      even-parity bit (frame = WIDTH+1 bits).
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 10;

  // Number of serial bits emitted per accepted word.
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // The counter must be able to hold FRAME_LEN itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(frame_len(width) + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/piso_hold_buf.sv
// -----------------------------------------------------------------------------
// piso_hold_buf
//   One-entry holding buffer in front of the serializer shift register.
//   It owns the valid/ready handshake: the upstream side is ready exactly
//   when the buffer is empty. A transfer either bypasses the buffer (the
//   serializer takes the word straight into its shift register) or is
//   captured here until the serializer pops it at the end of a frame.
//
//   Ports:
//     clk_i     - system clock, rising edge
//     reset_i   - asynchronous, active-high reset
//     data_i    - parallel word offered upstream
//     valid_i   - data_i is valid this cycle
//     bypass_i  - serializer loads a transferred word directly this edge
//     pop_i     - serializer takes the held word this edge
//     hold_o    - held word
//     full_o    - buffer holds a word
//     ready_o   - buffer can accept a word (== !full_o)
//     xfer_o    - a handshake completes on this edge
// -----------------------------------------------------------------------------
module piso_hold_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             bypass_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] hold_o,
  output logic             full_o,
  output logic             ready_o,
  output logic             xfer_o
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             capture;

  assign ready_o = ~full_q;
  assign xfer_o  = valid_i & ready_o;
  // A transfer lands here only when the serializer cannot take it directly.
  assign capture = xfer_o & ~bypass_i;

  // pop and capture are mutually exclusive: pop needs a full buffer while
  // capture needs ready, i.e. an empty one.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (pop_i) begin
      full_d = 1'b0;
    end else if (capture) begin
      hold_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold_o = hold_q;
  assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out transmitter for the 10-bit symbol link. Each word
//   accepted through the valid/ready handshake is shifted out MSB first, one
//   bit per clock, starting the cycle after the accepting edge. A one-entry
//   holding buffer lets consecutive words stream with no idle bit between
//   frames. The first bit sent lands in the receiver's highest Q index.
//
//   Parameters:
//     WIDTH        - parallel word width in bits (>= 2)
//
//   Ports:
//     clk          - system clock, rising edge
//     reset        - asynchronous, active-high reset
//     data_in      - parallel word to transmit
//     load_valid   - data_in is valid this cycle
//     load_ready   - a word can be accepted (holding buffer empty)
//     data_out     - serial bit; MSB of the shift register while shifting,
//                    0 when idle
//     out_valid    - data_out carries a frame bit
//     frame_start  - high for the first bit of every frame
//     busy         - shifting or holding a pending word
//
//   Configuration macro:
//     PISO_PARITY_EN - append an even-parity bit (XOR of the word) after the
//                      word's LSB; frames become WIDTH+1 bits long.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int SH_CNT_W  = cnt_width(WIDTH);
  localparam logic [SH_CNT_W-1:0] LAST_CNT = SH_CNT_W'(FRAME_LEN - 1);

  // Builds the shift-register image of a word: word bits at the top so the
  // MSB leaves first, parity (when enabled) in the LSB so it leaves last.
  function automatic logic [FRAME_LEN-1:0] frame_word(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  state_t                state_q, state_d;
  logic [FRAME_LEN-1:0]  sh_q, sh_d;
  logic [SH_CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]      hold_word;
  logic                  hold_full;
  logic                  xfer;
  logic                  shifting;
  logic                  last_bit;
  logic                  bypass;
  logic                  pop;

  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (cnt_q == LAST_CNT);

  // A transfer goes straight into the shift register when idle, or on the
  // last-bit edge; in the latter case the buffer is necessarily empty,
  // otherwise load_ready would have been low.
  assign bypass = ~shifting | last_bit;
  assign pop    = last_bit & hold_full;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk_i    (clk),
    .reset_i  (reset),
    .data_i   (data_in),
    .valid_i  (load_valid),
    .bypass_i (bypass),
    .pop_i    (pop),
    .hold_o   (hold_word),
    .full_o   (hold_full),
    .ready_o  (load_ready),
    .xfer_o   (xfer)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sh_d    = frame_word(data_in);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sh_d  = {sh_q[FRAME_LEN-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end else if (hold_full) begin
          // Pending word wins over any new offer; load_ready is low anyway.
          sh_d  = frame_word(hold_word);
          cnt_d = '0;
        end else if (xfer) begin
          sh_d  = frame_word(data_in);
          cnt_d = '0;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset aborts any frame in flight at once; the outputs below are decoded
  // straight from these registers, so they drop with the reset itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = shifting;
  assign data_out    = shifting & sh_q[FRAME_LEN-1];
  assign frame_start = shifting && (cnt_q == '0);
  assign busy        = shifting | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer (WIDTH = 10). Works with or without
//   PISO_PARITY_EN; the expected frame length follows the macro.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 10;
`ifdef PISO_PARITY_EN
  localparam int FL = 11;
  localparam logic T5_LAST0 = 1'b1;  // parity of 10'h001
  localparam logic T5_LAST1 = 1'b0;  // parity of 10'h003
`else
  localparam int FL = 10;
  localparam logic T5_LAST0 = 1'b1;  // LSB of 10'h001
  localparam logic T5_LAST1 = 1'b1;  // LSB of 10'h003
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         data_out;
  logic         out_valid;
  logic         frame_start;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] drv_q[$];
  logic [31:0]  first_bits;
  logic         frame_last[8];

  piso_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected bit b of the serial frame for word w.
  function automatic logic exp_bit(input logic [W-1:0] w, input int b);
    if (b < W) return w[W-1-b];
    return ^w;
  endfunction

  // Offer drv_q[0..n-1] in order; after each acceptance idle 'gap' cycles.
  task automatic drive_words(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      logic rdy;
      logic acc;
      int   t;
      data_in    = drv_q[i];
      load_valid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 100) begin
        rdy = load_ready;
        step();
        acc = rdy;
        t++;
      end
      check("drv_accept", {31'd0, acc}, 32'd1);
      data_in = 10'h2DB;  // later changes must not affect the frame
      if (gap > 0) begin
        load_valid = 1'b0;
        repeat (gap) step();
      end
    end
    load_valid = 1'b0;
  endtask

  // Check nframes contiguous frames against exp_q, then an idle cycle.
  // rdy_mode: 0 = no load_ready check, 1 = three-word streaming pattern,
  // 2 = load_ready always high.
  task automatic mon_frames(input int nframes, input int rdy_mode);
    int waitc = 0;
    while (!out_valid && waitc < 60) begin
      step();
      waitc++;
    end
    check("mon_start", {31'd0, out_valid}, 32'd1);
    if (out_valid) begin
      first_bits = '0;
      for (int f = 0; f < nframes; f++) begin
        for (int b = 0; b < FL; b++) begin
          int j;
          j = f * FL + b;
          check($sformatf("ov_f%0d_b%0d", f, b), {31'd0, out_valid}, 32'd1);
          check($sformatf("fs_f%0d_b%0d", f, b), {31'd0, frame_start}, {31'd0, (b == 0)});
          check($sformatf("bit_f%0d_b%0d", f, b), {31'd0, data_out}, {31'd0, exp_bit(exp_q[f], b)});
          if (rdy_mode == 1)
            check($sformatf("rdy_j%0d", j), {31'd0, load_ready},
                  {31'd0, (j == 0 || j == FL || j >= 2 * FL)});
          else if (rdy_mode == 2)
            check($sformatf("rdy_j%0d", j), {31'd0, load_ready}, 32'd1);
          if (f == 0) first_bits = {first_bits[30:0], data_out};
          if (b == FL - 1 && f < 8) frame_last[f] = data_out;
          if (!(f == nframes - 1 && b == FL - 1)) step();
        end
      end
      step();
      check("end_ov", {31'd0, out_valid}, 32'd0);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_rdy", {31'd0, load_ready}, 32'd1);
    end
  endtask

  initial begin
    int cnt_ov;

    // Reset state; handshakes offered during reset are ignored.
    reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 10'h3FF;
    #2;
    check("rst_dout", {31'd0, data_out}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, load_ready}, 32'd1);
    repeat (3) step();
    check("rst_ov_hs", {31'd0, out_valid}, 32'd0);
    load_valid = 1'b0;
    reset      = 1'b0;
    step();
    check("post_rst_ov", {31'd0, out_valid}, 32'd0);
    check("post_rst_rdy", {31'd0, load_ready}, 32'd1);

    // Single word.
    exp_q = '{10'h2A5};
    drv_q = '{10'h2A5};
    fork
      drive_words(1, 0);
      mon_frames(1, 2);
    join
    check("t1_hand_bits", (first_bits >> (FL - W)) & 32'h3FF, 32'b1010100101);

    // Three words, load_valid held high: 3*FL contiguous bits.
    exp_q = '{10'h3FF, 10'h000, 10'h155};
    drv_q = '{10'h3FF, 10'h000, 10'h155};
    fork
      drive_words(3, 0);
      mon_frames(3, 1);
    join

    // Second word offered exactly for the last-bit edge, buffer empty.
    exp_q = '{10'h2A5, 10'h0F0};
    drv_q = '{10'h2A5, 10'h0F0};
    fork
      drive_words(2, FL - 1);
      mon_frames(2, 2);
    join

    // Reset at bit 4 with a word held.
    data_in    = 10'h2A5;
    load_valid = 1'b1;
    step();
    data_in = 10'h0F0;
    step();
    load_valid = 1'b0;
    check("t4_rdy_full", {31'd0, load_ready}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd1);
    repeat (3) step();
    check("t4_ov_b4", {31'd0, out_valid}, 32'd1);
    check("t4_bit4", {31'd0, data_out}, 32'd1);
    #2;
    reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 10'h3C3;
    #1;
    check("t4_rst_dout", {31'd0, data_out}, 32'd0);
    check("t4_rst_ov", {31'd0, out_valid}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_rdy", {31'd0, load_ready}, 32'd1);
    repeat (2) step();
    load_valid = 1'b0;
    reset      = 1'b0;
    step();
    check("t4_rel_rdy", {31'd0, load_ready}, 32'd1);
    cnt_ov = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      if (out_valid || busy) cnt_ov++;
      step();
    end
    check("t4_residual", cnt_ov, 32'd0);

    // Trailing bit: parity when enabled, otherwise the word LSB.
    exp_q = '{10'h001, 10'h003};
    drv_q = '{10'h001, 10'h003};
    fork
      drive_words(2, 0);
      mon_frames(2, 0);
    join
    check("t5_last0", {31'd0, frame_last[0]}, {31'd0, T5_LAST0});
    check("t5_last1", {31'd0, frame_last[1]}, {31'd0, T5_LAST1});

    // Offers while load_ready is low are not transmitted.
    exp_q = '{10'h1C7, 10'h2B8};
    fork
      begin
        data_in    = 10'h1C7;
        load_valid = 1'b1;
        step();
        data_in = 10'h2B8;
        step();
        data_in = 10'h3C3;
        check("t6_rdy_low", {31'd0, load_ready}, 32'd0);
        repeat (3) step();
        load_valid = 1'b0;
      end
      mon_frames(2, 0);
    join
    cnt_ov = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      if (out_valid) cnt_ov++;
      step();
    end
    check("t6_no_extra", cnt_ov, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter for the 10-bit symbol link; it is the transmit-side counterpart of the SIPO deserializer.
- Accepts one WIDTH-bit parallel word per valid/ready handshake and shifts it out MSB first, one bit per clk.
- A one-entry holding buffer lets back-to-back words stream with no idle bit between frames.
- The first bit transmitted lands in the receiver's highest Q index.

Parameters:
- WIDTH, 10, parallel word width in bits (>= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  data_in is valid this cycle.
- load_ready  output  1  block can accept a word; equals !hold_full.
- data_out  output  1  serial bit; sh[FRAME_LEN-1] while shifting, 0 when idle.
- out_valid  output  1  data_out carries a frame bit.
- frame_start  output  1  high for exactly the first bit of each frame.
- busy  output  1  high when in SHIFT or hold_full.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Reset state: state=IDLE, sh=0, hold=0, hold_full=0, cnt=0.
  - Outputs during and after reset: data_out=0, out_valid=0, frame_start=0, busy=0, load_ready=1.
  - Handshakes are ignored while reset is high.
  - Reset mid-frame aborts the frame immediately; no partial bits follow, and any held word is discarded.
- Transfer: occurs on a rising edge with load_valid && load_ready.
- States: IDLE and SHIFT.
  - IDLE + transfer: sh<=data_in, cnt<=0, go to SHIFT. The first bit appears on data_out in the cycle after the accepting edge (latency 1).
  - SHIFT, cnt<FRAME_LEN-1: sh<=sh<<1 with 0 fill; cnt<=cnt+1.
  - SHIFT, cnt==FRAME_LEN-1 (last bit):
    - If hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
    - Else if a transfer occurs this edge: sh<=data_in directly, cnt<=0, stay in SHIFT.
    - Else: go to IDLE.
  - SHIFT + transfer (other than the direct load above): hold<=data_in, hold_full<=1.
- FRAME_LEN = WIDTH, or WIDTH+1 with parity enabled. cnt width is $clog2(FRAME_LEN+1).
- out_valid = (state==SHIFT). frame_start = out_valid && cnt==0.
- Back-to-back words produce a continuous out_valid with no gap.
- Holding-buffer rules:
  - When hold is full, load_ready=0 until the edge that moves hold into sh. It returns to 1 in the next cycle.
  - A new word cannot enter hold on that same edge, because load_ready was already low.
- A word is never dropped or duplicated; the serial order equals the acceptance order.
- data_in is sampled only at the transfer edge; later changes have no effect.

Optional Feature:
- Macro: PISO_PARITY_EN.
  - Defined: each frame is WIDTH+1 bits. The word's bits go out MSB first, then an even-parity bit (XOR of the word), computed at load and stored as the LSB of the extended sh.
  - Undefined: the frame is exactly WIDTH bits with no parity logic.
- The receiver must be configured to match.

Decomposition:
- Package piso_pkg:
  - state typedef (IDLE, SHIFT);
  - FRAME_LEN function of WIDTH and the macro;
  - CNT_W constant.
- One natural sub-module: piso_hold_buf, the one-entry buffer with the valid/ready logic (hold, hold_full, load_ready).

Test Plan:
- Reset then a single word 10'h2A5 -> serial 1,0,1,0,1,0,0,1,0,1 on the 10 cycles after acceptance; frame_start only on the first; then out_valid=0 and busy=0.
- Three words (10'h3FF, 10'h000, 10'h155) with load_valid held high -> 30 contiguous out_valid cycles; load_ready drops while hold is full; bits match the words in order.
- Word accepted exactly on the last-bit edge with hold empty -> no gap; frame_start on the next cycle.
- Assert reset at bit 4 of 10'h2A5 with a word held -> data_out=0 and out_valid=0 immediately; after release load_ready=1; no residual bits.
- PISO_PARITY_EN, words 10'h001 and 10'h003 -> 11-bit frames with trailing parity bits 1 and 0 respectively.
- load_valid pulses while load_ready=0 -> those words are not transmitted.
